loop_flow_ctrl_mux4: RTL and testbench

- Combines the handshake shim that wraps every HLS-generated sequential pipelined loop with a 4:1 data-word multiplexer used in the loop datapath.
- Flow-control section converts the caller's ap_start/ap_ready/ap_done handshake into loop-internal start, first-iteration and completion signals.
- Mux section selects one of four constant/variable words by a 2-bit index, e.g. the loop counter's low bits.
- The two sections share no state; they only share the clock/reset pins.

---
 rtl/loop_flow_ctrl_mux4.sv | 70 +++++++
 tb/tb_loop_flow_ctrl_mux4.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/loop_flow_ctrl_mux4.sv
// Handshake shim for a pipelined HLS loop plus an independent 4:1 word mux.
// The two sections share only the clock and reset pins.
module loop_flow_ctrl_mux4 #(
  parameter int ID        = 1,
  parameter int NUM_STAGE = 1,
  parameter int DIN_WIDTH = 32,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_start_int,
  output logic                 ap_loop_init,
  input  logic                 ap_ready_int,
  input  logic                 ap_loop_exit_ready,
  input  logic                 ap_loop_exit_done,
  output logic                 ap_continue_int,
  input  logic                 ap_done_int,
  input  logic [DIN_WIDTH-1:0] din0,
  input  logic [DIN_WIDTH-1:0] din1,
  input  logic [DIN_WIDTH-1:0] din2,
  input  logic [DIN_WIDTH-1:0] din3,
  input  logic [SEL_WIDTH-1:0] din4,
  output logic [DIN_WIDTH-1:0] dout
);

  logic init_reg;
  logic done_cache;
  logic unused_ok;

  assign unused_ok = ^{ap_done_int, ID[0], NUM_STAGE[0]};

  assign ap_start_int    = ap_start;
  assign ap_continue_int = 1'b1;
  assign ap_ready        = ap_loop_exit_ready;
  assign ap_loop_init    = init_reg & ap_start;
  assign ap_done         = ap_loop_exit_done
                         | (done_cache & ~ap_start);

  // Exit re-arms init even when the body also consumed an iteration.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      init_reg   <= 1'b1;
      done_cache <= 1'b0;
    end else begin
      if (ap_loop_exit_done)
        init_reg <= 1'b1;
      else if (ap_ready_int)
        init_reg <= 1'b0;
      if (ap_loop_exit_done)
        done_cache <= 1'b1;
      else if (ap_start)
        done_cache <= 1'b0;
    end
  end

  always_comb begin
    dout = din0;
    case (din4)
      SEL_WIDTH'(0): dout = din0;
      SEL_WIDTH'(1): dout = din1;
      SEL_WIDTH'(2): dout = din2;
      SEL_WIDTH'(3): dout = din3;
      default:       dout = din0;
    endcase
  end

endmodule

// File: tb/tb_loop_flow_ctrl_mux4.sv
// Directed and random checks of the loop handshake shim and word mux
// against an event-history reference model.
module tb_loop_flow_ctrl_mux4;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_start_int;
  logic        ap_loop_init;
  logic        ap_ready_int;
  logic        ap_loop_exit_ready;
  logic        ap_loop_exit_done;
  logic        ap_continue_int;
  logic        ap_done_int;
  logic [31:0] din0, din1, din2, din3;
  logic [1:0]  din4;
  logic [31:0] dout;

  int total = 0;
  int fails = 0;

  // Model: iterations accepted since the last exit/reset, and the cycle
  // numbers of the most recent exit and most recent start-without-exit.
  int iters = 0;
  int cycle = 0;
  int last_exit = -1;
  int last_clear = -1;
  logic [31:0] dref [4];

  loop_flow_ctrl_mux4 dut (
    .ap_clk             (ap_clk),
    .ap_rst_n           (ap_rst_n),
    .ap_start           (ap_start),
    .ap_ready           (ap_ready),
    .ap_done            (ap_done),
    .ap_start_int       (ap_start_int),
    .ap_loop_init       (ap_loop_init),
    .ap_ready_int       (ap_ready_int),
    .ap_loop_exit_ready (ap_loop_exit_ready),
    .ap_loop_exit_done  (ap_loop_exit_done),
    .ap_continue_int    (ap_continue_int),
    .ap_done_int        (ap_done_int),
    .din0               (din0),
    .din1               (din1),
    .din2               (din2),
    .din3               (din3),
    .din4               (din4),
    .dout               (dout)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    iters = 0;
    last_exit = -1;
    last_clear = -1;
  endtask

  task automatic check_outputs(input int ei, input int ed);
    logic ex_init;
    logic ex_done;
    ex_init = (iters == 0) && ap_start;
    ex_done = ap_loop_exit_done
            | ((last_exit > last_clear) && !ap_start);
    chk("loop_init", {31'd0, ap_loop_init}, {31'd0, ex_init});
    chk("done", {31'd0, ap_done}, {31'd0, ex_done});
    chk("ready", {31'd0, ap_ready}, {31'd0, ap_loop_exit_ready});
    chk("start_int", {31'd0, ap_start_int}, {31'd0, ap_start});
    chk("continue", {31'd0, ap_continue_int}, 32'd1);
    chk("dout", dout, dref[din4]);
    if (ei >= 0) chk("plan_init", {31'd0, ap_loop_init}, ei);
    if (ed >= 0) chk("plan_done", {31'd0, ap_done}, ed);
  endtask

  task automatic set_mux();
    dref[0] = $urandom;
    dref[1] = $urandom;
    dref[2] = $urandom;
    dref[3] = $urandom;
    din0 = dref[0];
    din1 = dref[1];
    din2 = dref[2];
    din3 = dref[3];
    din4 = 2'($urandom_range(0, 3));
  endtask

  task automatic cyc(input logic s, input logic r, input logic xr,
                     input logic xd, input int ei, input int ed);
    @(negedge ap_clk);
    ap_start = s;
    ap_ready_int = r;
    ap_loop_exit_ready = xr;
    ap_loop_exit_done = xd;
    ap_done_int = 1'($urandom);
    set_mux();
    #1;
    check_outputs(ei, ed);
    @(posedge ap_clk);
    cycle++;
    if (ap_rst_n) begin
      if (xd) begin
        iters = 0;
        last_exit = cycle;
      end else begin
        if (r) iters++;
        if (s) last_clear = cycle;
      end
    end
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    ap_ready_int = 1'b0;
    ap_loop_exit_ready = 1'b0;
    ap_loop_exit_done = 1'b0;
    ap_done_int = 1'b0;
    set_mux();
    model_reset();

    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    #2 ap_rst_n = 1'b1;

    // Idle, then a 4-iteration run ending with exit in cycle 5.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 1);
    cyc(1, 1, 0, 0, 1, 0);

    // Done holds while start is low, clears when start rises.
    cyc(1, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Single-iteration runs back to back.
    cyc(1, 1, 1, 1, 1, 1);
    cyc(1, 1, 1, 1, 1, 1);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Asynchronous reset between edges, start still high.
    #2 ap_rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_init", {31'd0, ap_loop_init}, 32'd1);
    chk("async_done", {31'd0, ap_done}, 32'd0);
    cyc(1, 0, 0, 0, 1, 0);
    #2 ap_rst_n = 1'b1;
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Mux sweep with no clock dependency.
    @(negedge ap_clk);
    dref[0] = 32'd655360;
    dref[1] = 32'h1234_5678;
    dref[2] = 32'hFFFF_FFFF;
    dref[3] = 32'd0;
    din0 = 32'd655360;
    din1 = 32'h1234_5678;
    din2 = 32'hFFFF_FFFF;
    din3 = 32'd0;
    for (int i = 0; i < 4; i++) begin
      din4 = 2'(i);
      #1;
      chk("mux_sweep", dout, dref[i]);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
          ($urandom % 5) == 0, -1, -1);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
